// File: rtl/seg_codes_pkg.sv
// Character codes, slot format and scan states shared by the seven-segment
// decoder and the display scanner.
package seg_codes_pkg;

    localparam logic MODE_NUMBER   = 1'b0;
    localparam logic MODE_ALPHABET = 1'b1;

    localparam logic [3:0] C_SPACE = 4'd0;
    localparam logic [3:0] C_A     = 4'd1;
    localparam logic [3:0] C_B     = 4'd2;
    localparam logic [3:0] C_C     = 4'd3;
    localparam logic [3:0] C_D     = 4'd4;
    localparam logic [3:0] C_E     = 4'd5;
    localparam logic [3:0] C_F     = 4'd6;
    localparam logic [3:0] C_H     = 4'd7;
    localparam logic [3:0] C_L     = 4'd8;
    localparam logic [3:0] C_N     = 4'd9;
    localparam logic [3:0] C_O     = 4'd10;
    localparam logic [3:0] C_P     = 4'd11;
    localparam logic [3:0] C_R     = 4'd12;
    localparam logic [3:0] C_T     = 4'd13;
    localparam logic [3:0] C_U     = 4'd14;

    typedef struct packed {
        logic       mode;
        logic [3:0] value;
    } slot_t;

    localparam slot_t BLANK_SLOT = '{mode: MODE_ALPHABET, value: C_SPACE};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timing for the display scanner: prescaler, BLANK/DRIVE phase, digit
// index and the frame wrap.
module seg_scan_timer
    import seg_codes_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output scan_state_t      state,
    output logic [IDX_W-1:0] index,
    output logic             wrap,
    output logic             frame_tick
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_nx;
    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_nx;
    logic [IDX_W-1:0] index_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            index      <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            index      <= index_nx;
            frame_tick <= wrap;
        end
    end

    // Dropping enable wins over everything, even in the middle of a slot.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        index_nx = index;
        wrap     = 1'b0;
        if (!enable) begin
            state_nx = ST_IDLE;
            presc_nx = '0;
            index_nx = '0;
        end else if (state == ST_IDLE) begin
            state_nx = ST_BLANK;
            presc_nx = '0;
            index_nx = '0;
        end else if (presc == PRE_LAST) begin
            presc_nx = '0;
            state_nx = ST_BLANK;
            if (index == IDX_LAST) begin
                index_nx = '0;
                wrap     = 1'b1;
            end else begin
                index_nx = index + 1'b1;
            end
        end else begin
            presc_nx = presc + 1'b1;
            if (presc == BLANK_LAST) begin
                state_nx = ST_DRIVE;
            end
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexes one character slot per digit onto a single seven-segment decoder,
// with anti-ghosting blank gaps, per-digit blink and frame-aligned updates.
module seg_display_scanner
    import seg_codes_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [3:0]              value,
    output logic                    mode,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    scan_state_t                state;
    logic [IDX_W-1:0]           index;
    logic                       wrap;
    logic                       leave_idle;
    slot_t [NUM_DIGITS-1:0]     shadow_slots;
    slot_t [NUM_DIGITS-1:0]     active_slots;
    logic [NUM_DIGITS-1:0]      shadow_mask;
    logic [NUM_DIGITS-1:0]      active_mask;
    logic [BLINK_W-1:0]         frame_cnt;
    logic                       blink_phase;
    logic [NUM_DIGITS-1:0]      sel_nx;
    slot_t                      slot_nx;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .state      (state),
        .index      (index),
        .wrap       (wrap),
        .frame_tick (frame_tick)
    );

    assign leave_idle = enable && (state == ST_IDLE);

    // Active only changes at frame boundaries so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_slots <= {NUM_DIGITS{BLANK_SLOT}};
            active_slots <= {NUM_DIGITS{BLANK_SLOT}};
            shadow_mask  <= '0;
            active_mask  <= '0;
        end else begin
            if (load) begin
                shadow_slots <= digits_in;
                shadow_mask  <= blink_mask;
            end
            if (wrap || leave_idle) begin
                active_slots <= shadow_slots;
                active_mask  <= shadow_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!enable || state == ST_IDLE) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // A blinking digit stays selected but is fed the blank code.
    always_comb begin
        sel_nx  = '1;
        slot_nx = BLANK_SLOT;
        if (enable && state == ST_DRIVE) begin
            sel_nx[index] = 1'b0;
            if (!(blink_phase && active_mask[index])) begin
                slot_nx = active_slots[index];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_n <= '1;
            value       <= C_SPACE;
            mode        <= MODE_ALPHABET;
        end else begin
            digit_sel_n <= sel_nx;
            value       <= slot_nx.value;
            mode        <= slot_nx.mode;
        end
    end

endmodule
